// File: rtl/prog_counter_v2_if.sv
// Control/status bundle for prog_counter_v2: controller drives the master side,
// the counter sits on the slave side.
interface prog_counter_v2_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [PRE_W-1:0] prescale;
  logic             clr_flag;
  logic [WIDTH-1:0] count;
  logic             tc_pulse;
  logic             ovf_sticky;
  logic             done;

  modport master (
    output load, load_val, enable, dir, mode, limit, prescale, clr_flag,
    input  count, tc_pulse, ovf_sticky, done
  );

  modport slave (
    input  load, load_val, enable, dir, mode, limit, prescale, clr_flag,
    output count, tc_pulse, ovf_sticky, done
  );
endinterface

// File: rtl/prog_counter_v2.sv
// Programmable up/down counter with prescaler, limit register and
// wrap / modulo / one-shot / ping-pong modes plus tc, sticky-overflow and done flags.
module prog_counter_v2 #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  prog_counter_v2_if.slave bus
);
  typedef enum logic [1:0] {M_WRAP, M_MOD, M_ONESHOT, M_PP} mode_e;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [PRE_W-1:0] PONE = PRE_W'(1);

  logic [WIDTH-1:0] count_q, count_n;
  logic [PRE_W-1:0] pre_q, pre_n;
  logic             dir_q, dir_n;
  logic             done_q, done_n;
  logic             tc_q, tc_n;
  logic             ovf_q, ovf_n;
  logic             up;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);
  // Ping-pong follows its own direction latch; other modes follow the live pin.
  assign up   = (mode == M_PP) ? !dir_q : !bus.dir;

  always_comb begin
    count_n = count_q;
    pre_n   = pre_q;
    dir_n   = dir_q;
    done_n  = done_q;
    tc_n    = 1'b0;
    if (bus.load) begin
      count_n = bus.load_val;
      pre_n   = '0;
      done_n  = 1'b0;
      dir_n   = bus.dir;
    end else if (bus.enable && !done_q) begin
      if (pre_q != bus.prescale) begin
        pre_n = pre_q + PONE;
      end else begin
        pre_n = '0;
        case (mode)
          M_WRAP: begin
            count_n = up ? count_q + ONE : count_q - ONE;
            tc_n    = up ? (count_q == MAXV) : (count_q == '0);
          end
          M_MOD: begin
            if (up) begin
              if (count_q >= bus.limit) begin count_n = '0; tc_n = 1'b1; end
              else count_n = count_q + ONE;
            end else begin
              if (count_q == '0) begin count_n = bus.limit; tc_n = 1'b1; end
              else count_n = count_q - ONE;
            end
          end
          M_ONESHOT: begin
            // Already at/past terminal: just latch done, no fresh tc.
            if (up) begin
              if (count_q >= bus.limit) done_n = 1'b1;
              else begin
                count_n = count_q + ONE;
                if (count_q + ONE == bus.limit) begin tc_n = 1'b1; done_n = 1'b1; end
              end
            end else begin
              if (count_q == '0) done_n = 1'b1;
              else begin
                count_n = count_q - ONE;
                if (count_q == ONE) begin tc_n = 1'b1; done_n = 1'b1; end
              end
            end
          end
          M_PP: begin
            if (bus.limit == '0) count_n = '0;
            else if (up) begin
              if (count_q >= bus.limit) begin
                dir_n = 1'b1; count_n = count_q - ONE; tc_n = 1'b1;
              end else count_n = count_q + ONE;
            end else begin
              if (count_q == '0) begin
                dir_n = 1'b0; count_n = count_q + ONE; tc_n = 1'b1;
              end else count_n = count_q - ONE;
            end
          end
        endcase
      end
    end
    ovf_n = tc_n ? 1'b1 : (bus.clr_flag ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_n;
      pre_q   <= pre_n;
      dir_q   <= dir_n;
      done_q  <= done_n;
      tc_q    <= tc_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc_pulse   = tc_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_prog_counter_v2.sv
// Bench for prog_counter_v2: vector table, directed corner sequences and
// random stimulus against an arithmetic reference model.
module tb_prog_counter_v2;
  localparam int W    = 8;
  localparam int P    = 4;
  localparam int MODV = 1 << W;
  localparam int PMOD = 1 << P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int m_count, m_pre;
  bit m_dir, m_done, m_tc, m_ovf;

  prog_counter_v2_if #(.WIDTH(W), .PRE_W(P)) bus ();
  prog_counter_v2 #(.WIDTH(W), .PRE_W(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       dr;
    logic [1:0] md;
    logic [7:0] lim;
    logic [3:0] ps;
    logic       clr;
    logic [7:0] e_cnt;
    logic       e_tc;
    logic       e_ovf;
    logic       e_done;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, " count"}, int'(bus.count), m_count);
    chk({tag, " tc"},    int'(bus.tc_pulse), int'(m_tc));
    chk({tag, " ovf"},   int'(bus.ovf_sticky), int'(m_ovf));
    chk({tag, " done"},  int'(bus.done), int'(m_done));
  endtask

  task automatic model_reset();
    m_count = 0; m_pre = 0; m_dir = 0; m_done = 0; m_tc = 0; m_ovf = 0;
  endtask

  // Next state straight from the mode rules, in plain integer arithmetic.
  task automatic model_step();
    int c, lim, nxt;
    bit up, tc;
    c = m_count; lim = int'(bus.limit); nxt = c; tc = 0;
    if (bus.load) begin
      m_count = int'(bus.load_val); m_pre = 0; m_done = 0; m_dir = bus.dir;
    end else if (bus.enable && !m_done) begin
      if (m_pre != int'(bus.prescale)) m_pre = (m_pre + 1) % PMOD;
      else begin
        m_pre = 0;
        up = (bus.mode == 2'd3) ? !m_dir : !bus.dir;
        case (bus.mode)
          2'd0: begin
            nxt = up ? (c + 1) % MODV : (c + MODV - 1) % MODV;
            tc  = up ? (nxt == 0) : (c == 0);
          end
          2'd1: begin
            if (up) begin if (c >= lim) begin nxt = 0; tc = 1; end else nxt = c + 1; end
            else    begin if (c == 0) begin nxt = lim; tc = 1; end else nxt = c - 1; end
          end
          2'd2: begin
            if (up) begin
              if (c >= lim) m_done = 1;
              else begin nxt = c + 1; if (nxt == lim) begin tc = 1; m_done = 1; end end
            end else begin
              if (c == 0) m_done = 1;
              else begin nxt = c - 1; if (nxt == 0) begin tc = 1; m_done = 1; end end
            end
          end
          default: begin
            if (lim == 0) nxt = 0;
            else if (up) begin
              if (c >= lim) begin m_dir = 1; nxt = c - 1; tc = 1; end else nxt = c + 1;
            end else begin
              if (c == 0) begin m_dir = 0; nxt = c + 1; tc = 1; end else nxt = c - 1;
            end
          end
        endcase
        m_count = nxt;
      end
    end
    m_tc = tc;
    if (tc) m_ovf = 1; else if (bus.clr_flag) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(logic ld, logic [7:0] lv, logic en, logic dr, logic [1:0] md,
                       logic [7:0] lim, logic [3:0] ps, logic clr);
    bus.load = ld; bus.load_val = lv; bus.enable = en; bus.dir = dr;
    bus.mode = md; bus.limit = lim; bus.prescale = ps; bus.clr_flag = clr;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("reset count", int'(bus.count), 0);
    chk("reset tc",    int'(bus.tc_pulse), 0);
    chk("reset ovf",   int'(bus.ovf_sticky), 0);
    chk("reset done",  int'(bus.done), 0);
    rst_n = 1'b1;

    // wrap rollover, then ping-pong limit 2 (dir toggled mid-run)
    tbl.push_back('{1, 8'hFE, 0, 0, 0, 0, 0, 0, 8'hFE, 0, 0, 0});
    tbl.push_back('{0, 0,     1, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0});
    tbl.push_back('{0, 0,     1, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0});
    tbl.push_back('{0, 0,     1, 0, 0, 0, 0, 0, 8'h01, 0, 1, 0});
    tbl.push_back('{1, 0,     0, 0, 3, 2, 0, 1, 8'h00, 0, 0, 0});
    tbl.push_back('{0, 0,     1, 0, 3, 2, 0, 0, 8'h01, 0, 0, 0});
    tbl.push_back('{0, 0,     1, 1, 3, 2, 0, 0, 8'h02, 0, 0, 0});
    tbl.push_back('{0, 0,     1, 0, 3, 2, 0, 0, 8'h01, 1, 1, 0});
    tbl.push_back('{0, 0,     1, 0, 3, 2, 0, 0, 8'h00, 0, 1, 0});
    tbl.push_back('{0, 0,     1, 1, 3, 2, 0, 0, 8'h01, 1, 1, 0});
    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].dr, tbl[i].md, tbl[i].lim, tbl[i].ps, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d count", i), int'(bus.count), int'(tbl[i].e_cnt));
      chk($sformatf("vec%0d tc", i),    int'(bus.tc_pulse), int'(tbl[i].e_tc));
      chk($sformatf("vec%0d ovf", i),   int'(bus.ovf_sticky), int'(tbl[i].e_ovf));
      chk($sformatf("vec%0d done", i),  int'(bus.done), int'(tbl[i].e_done));
    end

    // modulo, limit 5, prescale 2: up 0..5,0 then down 0->5
    drive(1, 0, 0, 0, 1, 5, 2, 1); tick(); chk_model("mod load");
    drive(0, 0, 1, 0, 1, 5, 2, 0);
    for (int i = 0; i < 18; i++) begin
      tick(); chk_model("mod up");
      if (i == 1)  chk("mod prescale hold", int'(bus.count), 0);
      if (i == 2)  chk("mod first step", int'(bus.count), 1);
      if (i == 14) chk("mod at limit", int'(bus.count), 5);
      if (i == 17) begin chk("mod wrap", int'(bus.count), 0); chk("mod wrap tc", int'(bus.tc_pulse), 1); end
    end
    bus.dir = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("mod down count", int'(bus.count), 5);
    chk("mod down tc", int'(bus.tc_pulse), 1);
    chk_model("mod down");

    // one-shot limit 3
    drive(1, 0, 0, 0, 2, 3, 0, 1); tick();
    drive(0, 0, 1, 0, 2, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(); chk_model("os run"); end
    chk("os done", int'(bus.done), 1);
    chk("os tc", int'(bus.tc_pulse), 1);
    tick(); tick();
    chk("os hold count", int'(bus.count), 3);
    chk("os hold tc", int'(bus.tc_pulse), 0);
    bus.mode = 2'd0; tick();
    chk("os mode change keeps done", int'(bus.done), 1);
    drive(1, 0, 0, 0, 2, 3, 0, 0); tick();
    chk("os load clears done", int'(bus.done), 0);
    chk_model("os reload");

    // load beats step; tc beats clr_flag
    drive(1, 8'h42, 1, 0, 0, 0, 0, 0); tick();
    chk("load wins", int'(bus.count), 8'h42);
    drive(1, 8'hFF, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 0, 0, 0, 0, 1); tick();
    chk("clr+tc count", int'(bus.count), 0);
    chk("clr+tc ovf", int'(bus.ovf_sticky), 1);
    tick();
    chk("clr after", int'(bus.ovf_sticky), 0);
    chk_model("simul");

    // async reset with prescaler partway
    drive(1, 8'h10, 0, 0, 0, 0, 3, 0); tick();
    drive(0, 0, 1, 0, 0, 0, 3, 0); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count", int'(bus.count), 0);
    chk("async rst done", int'(bus.done), 0);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("post rst no step", int'(bus.count), 0); end
    tick();
    chk("post rst first step", int'(bus.count), 1);
    chk_model("post rst");

    // random
    for (int i = 0; i < 600; i++) begin
      bus.load     = ($urandom_range(0, 19) == 0);
      bus.load_val = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      bus.enable   = ($urandom_range(0, 5) != 0);
      bus.dir      = ($urandom_range(0, 9) == 0) ? ~bus.dir : bus.dir;
      if ($urandom_range(0, 24) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 24) == 0)
        bus.limit = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 10));
      if ($urandom_range(0, 24) == 0) bus.prescale = P'($urandom_range(0, 3));
      bus.clr_flag = ($urandom_range(0, 7) == 0);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
